// File: rtl/ahfp_lzd_pipe.sv
// ahfp_lzd_pipe -- pipelined leading/trailing-zero detector and normaliser.
//
// Sits between the mantissa adder/subtractor and exponent adjust/rounding.
// Stage 1 finds the priority one and registers the zero count. Stage 2
// registers the bit index and the normalised operand. Both stages use
// valid/ready handshakes, and there is no skid buffer.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready input handshake
//   in_data [WIDTH]   operand (mantissa)
//   in_mode           0: leading-zero count and normalise, 1: trailing-zero count
//   in_tag  [TAG_W]   sideband tag, passed through unchanged
//   out_valid/out_ready output handshake
//   out_count [CNT_W] zero count (0 for an all-zero operand)
//   out_index [CNT_W] bit index of the detected one
//   out_zero          operand was all zeros
//   out_norm [WIDTH]  data << count in mode 0, data unchanged in mode 1
//   out_tag [TAG_W]   tag of this result

// Recursive priority tree over a power-of-two vector. It reports whether any
// bit is set and the index of the highest set bit (LSB_FIRST=0) or the lowest
// set bit (LSB_FIRST=1).
module ahfp_lzd_tree #(
  parameter int N         = 2,
  parameter bit LSB_FIRST = 1'b0,
  localparam int W        = $clog2(N)
) (
  input  logic [N-1:0] data,
  output logic         found,
  output logic [W-1:0] idx
);
  if (N == 2) begin : g_leaf
    assign found = |data;
    assign idx   = LSB_FIRST ? !data[0] : data[1];
  end else begin : g_node
    logic         lo_found, hi_found, take_hi;
    logic [W-2:0] lo_idx, hi_idx;

    ahfp_lzd_tree #(.N(N/2), .LSB_FIRST(LSB_FIRST)) u_lo (
      .data(data[N/2-1:0]), .found(lo_found), .idx(lo_idx)
    );
    ahfp_lzd_tree #(.N(N/2), .LSB_FIRST(LSB_FIRST)) u_hi (
      .data(data[N-1:N/2]), .found(hi_found), .idx(hi_idx)
    );

    assign found   = lo_found | hi_found;
    assign take_hi = LSB_FIRST ? !lo_found : hi_found;
    assign idx     = take_hi ? {1'b1, hi_idx} : {1'b0, lo_idx};
  end
endmodule

module ahfp_lzd_pipe #(
  parameter int WIDTH  = 48,
  parameter int TAG_W  = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic [CNT_W-1:0] out_index,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_norm,
  output logic [TAG_W-1:0] out_tag
);
  // The operand is padded with zeros above the true MSB. Padding bits can
  // never win the search, so the tree indices are the true bit positions.
  localparam int P = 1 << CNT_W;
  localparam logic [CNT_W-1:0] MSB_IDX = CNT_W'(WIDTH - 1);

  logic [P-1:0]     padded;
  logic             hi_found, lo_found, zero_d;
  logic [CNT_W-1:0] hi_idx, lo_idx, count_d;

  logic             s1_valid, s1_mode, s1_zero;
  logic [WIDTH-1:0] s1_data;
  logic [TAG_W-1:0] s1_tag;
  logic [CNT_W-1:0] s1_count;
  logic             s2_valid, s1_adv, s2_adv;

  always_comb begin
    padded              = '0;
    padded[WIDTH-1:0]   = in_data;
  end

  ahfp_lzd_tree #(.N(P), .LSB_FIRST(1'b0)) u_msb_tree (
    .data(padded), .found(hi_found), .idx(hi_idx)
  );
  ahfp_lzd_tree #(.N(P), .LSB_FIRST(1'b1)) u_lsb_tree (
    .data(padded), .found(lo_found), .idx(lo_idx)
  );

  always_comb begin
    zero_d  = in_mode ? !lo_found : !hi_found;
    count_d = '0;
    if (!zero_d) count_d = in_mode ? lo_idx : MSB_IDX - hi_idx;
  end

  // NOTE: in_ready is combinational from out_ready. A full pipeline can still
  // accept a beat in the same cycle that its result drains, so there are no
  // bubbles.
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // NOTE: the datapath registers are reset along with the valids. This keeps
  // the outputs at a defined 0 during and right after reset. Every state
  // update uses non-blocking assignment, so both stages sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_data  <= '0;
      s1_tag   <= '0;
      s1_count <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode  <= in_mode;
        s1_zero  <= zero_d;
        s1_data  <= in_data;
        s1_tag   <= in_tag;
        s1_count <= count_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      out_count <= '0;
      out_index <= '0;
      out_zero  <= 1'b0;
      out_norm  <= '0;
      out_tag   <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_count <= s1_count;
        out_zero  <= s1_zero;
        out_tag   <= s1_tag;
        // The count is at most WIDTH-1, so the shift stays inside the word.
        out_norm  <= s1_mode ? s1_data : (s1_data << s1_count);
        if (s1_zero)      out_index <= '0;
        else if (s1_mode) out_index <= s1_count;
        else              out_index <= MSB_IDX - s1_count;
      end
    end
  end
endmodule
